m68k_irq_ctrl: RTL

Parametrised interrupt controller for the fx68k-based system. It sits between peripheral interrupt sources (VBlank, user_in pins, timers) and the CPU IPL pins, and replaces the fixed 3-source edge latch in the system top. Each source has software-programmable enable, edge/level mode, polarity and priority level (1–7). The block handles 68000 autovector acknowledge cycles and clears the serviced source.

---
 rtl/m68k_irq_pkg.sv | 23 ++
 rtl/irq_src_sync.sv | 41 ++++
 rtl/m68k_irq_ctrl.sv | 217 +++++++++++++++++++++
 3 files changed

// File: rtl/m68k_irq_pkg.sv
// Shared constants and types for the 68000 interrupt controller.
package m68k_irq_pkg;

  // Word addresses of the register window
  localparam logic [2:0] IRQ_PENDING  = 3'd0;
  localparam logic [2:0] IRQ_ENABLE   = 3'd1;
  localparam logic [2:0] IRQ_MODE     = 3'd2;
  localparam logic [2:0] IRQ_POLARITY = 3'd3;
  localparam logic [2:0] IRQ_LEVEL0   = 3'd4;

  // Active-low IPL encoding meaning "no interrupt requested"
  localparam logic [2:0] IPL_NONE = 3'b111;

  // Function code driven by the 68000 during an interrupt acknowledge cycle
  localparam logic [2:0] FC_IACK = 3'b111;

  typedef enum logic [1:0] {
    ACK_IDLE = 2'd0,
    ACK_ACK  = 2'd1,
    ACK_WAIT = 2'd2
  } ack_state_e;

endpackage

// File: rtl/irq_src_sync.sv
// Per-source input conditioning: synchroniser, one-cycle history, and the
// edge / level detection relative to the programmed polarity.
module irq_src_sync #(
  parameter int SYNC_STAGES = 2
) (
  input  logic clk,
  input  logic reset,
  input  logic src_i,
  input  logic polarity_i,
  output logic edge_o,
  output logic level_o
);

  logic [SYNC_STAGES-1:0] sync_q;
  logic                   s_prev_q;
  logic                   s;

  assign s = sync_q[SYNC_STAGES-1];

  // Shift the raw input through the synchroniser and keep one cycle of history
  always_ff @(posedge clk) begin
    if (reset) begin
      sync_q   <= '0;
      s_prev_q <= 1'b0;
    end else begin
      sync_q[0] <= src_i;
      for (int k = 1; k < SYNC_STAGES; k++) begin
        sync_q[k] <= sync_q[k-1];
      end
      s_prev_q <= s;
    end
  end

  // Edges are taken on the raw synchronised value so that flipping the
  // polarity register never looks like an edge.
  always_comb begin
    edge_o  = polarity_i ? (s_prev_q & ~s) : (~s_prev_q & s);
    level_o = s ^ polarity_i;
  end

endmodule

// File: rtl/m68k_irq_ctrl.sv
// Prioritising interrupt controller for the fx68k system: register window,
// per-source pending logic, IPL encoding and autovector acknowledge handling.
//
//   state    | meaning
//   ACK_IDLE | normal operation, ipl_n follows the highest eligible level
//   ACK_ACK  | single cycle in which the acknowledge result is presented
//   ACK_WAIT | waiting for the CPU to release AS, ipl_n held inactive
module m68k_irq_ctrl
  import m68k_irq_pkg::*;
#(
  parameter int NUM_SRC     = 8,
  parameter int SYNC_STAGES = 2
) (
  input  logic               clk,
  input  logic               reset,
  input  logic [NUM_SRC-1:0] src,
  input  logic               cs,
  input  logic [1:0]         wr,
  input  logic [2:0]         address,
  input  logic [15:0]        din,
  output logic [15:0]        dout,
  input  logic [2:0]         cpu_fc,
  input  logic               cpu_as_n,
  input  logic [2:0]         iack_level,
  output logic [2:0]         ipl_n,
  output logic               ack_valid,
  output logic               ack_hit,
  output logic [3:0]         ack_src
);

  localparam int PRIME_W = $clog2(SYNC_STAGES + 2);
  localparam logic [PRIME_W-1:0] PRIME_INIT = PRIME_W'(SYNC_STAGES + 1);

  logic [NUM_SRC-1:0] pending_q, pending_d;
  logic [NUM_SRC-1:0] enable_q, enable_d;
  logic [NUM_SRC-1:0] mode_q, mode_d;
  logic [NUM_SRC-1:0] polarity_q, polarity_d;
  logic [2:0]         level_q [NUM_SRC];
  logic [2:0]         level_d [NUM_SRC];

  logic [PRIME_W-1:0] prime_q, prime_d;
  logic               priming;

  ack_state_e         state_q, state_d;
  logic [2:0]         ipl_n_q, ipl_n_d;
  logic               ack_valid_q, ack_valid_d;
  logic               ack_hit_q, ack_hit_d;
  logic [3:0]         ack_src_q, ack_src_d;

  logic [NUM_SRC-1:0] edge_ev;
  logic [NUM_SRC-1:0] level_act;
  logic [NUM_SRC-1:0] eligible;
  logic [15:0]        wmask16;
  logic               ack_start;
  logic [2:0]         target;
  logic               hit;
  logic [3:0]         hit_idx;

  logic [15:0]        pend16, en16, mode16, pol16;
  logic [15:0]        lvl16 [4];

  // din bits beyond the implemented sources are simply not stored
  logic               unused_din;
  assign unused_din = ^din;

  for (genvar g = 0; g < NUM_SRC; g++) begin : g_src
    irq_src_sync #(
      .SYNC_STAGES(SYNC_STAGES)
    ) u_sync (
      .clk        (clk),
      .reset      (reset),
      .src_i      (src[g]),
      .polarity_i (polarity_q[g]),
      .edge_o     (edge_ev[g]),
      .level_o    (level_act[g])
    );
  end

  assign wmask16   = {{8{cs & wr[1]}}, {8{cs & wr[0]}}};
  assign priming   = (prime_q != '0);
  assign ack_start = (state_q == ACK_IDLE) && (cpu_fc == FC_IACK) && !cpu_as_n;

  // Eligibility, highest requested level and the acknowledge match search
  always_comb begin
    eligible = '0;
    target   = 3'd0;
    hit      = 1'b0;
    hit_idx  = 4'd0;
    for (int i = 0; i < NUM_SRC; i++) begin
      eligible[i] = pending_q[i] & enable_q[i] & (level_q[i] != 3'd0);
      if (eligible[i] && (level_q[i] > target)) begin
        target = level_q[i];
      end
    end
    // walk downwards so the lowest matching index is the one left standing
    for (int i = NUM_SRC - 1; i >= 0; i--) begin
      if (eligible[i] && (level_q[i] == iack_level)) begin
        hit     = 1'b1;
        hit_idx = 4'(i);
      end
    end
  end

  // Register writes and pending update; a fresh edge beats any clear
  always_comb begin
    enable_d   = enable_q;
    mode_d     = mode_q;
    polarity_d = polarity_q;
    pending_d  = pending_q;
    for (int i = 0; i < NUM_SRC; i++) begin
      level_d[i] = level_q[i];
    end
    for (int i = 0; i < NUM_SRC; i++) begin
      if (wmask16[i]) begin
        if (address == IRQ_ENABLE)   enable_d[i]   = din[i];
        if (address == IRQ_MODE)     mode_d[i]     = din[i];
        if (address == IRQ_POLARITY) polarity_d[i] = din[i];
      end
      if ((address == IRQ_LEVEL0 + 3'(i / 4)) && wmask16[(i % 4) * 4]) begin
        level_d[i] = din[(i % 4) * 4 +: 3];
      end
      if (mode_q[i]) begin
        pending_d[i] = (edge_ev[i] & ~priming)
                     | (pending_q[i]
                        & ~((address == IRQ_PENDING) & wmask16[i] & din[i])
                        & ~(ack_start & hit & (hit_idx == 4'(i))));
      end else begin
        pending_d[i] = level_act[i];
      end
    end
  end

  // Acknowledge sequencing and the registered CPU-facing outputs
  always_comb begin
    state_d = state_q;
    unique case (state_q)
      ACK_IDLE: if (ack_start) state_d = ACK_ACK;
      ACK_ACK:  state_d = ACK_WAIT;
      ACK_WAIT: if (cpu_as_n) state_d = ACK_IDLE;
      default:  state_d = ACK_IDLE;
    endcase
    ipl_n_d     = (state_d == ACK_IDLE) ? ~target : IPL_NONE;
    ack_valid_d = ack_start;
    ack_hit_d   = ack_start & hit;
    ack_src_d   = (ack_start & hit) ? hit_idx : ack_src_q;
    prime_d     = priming ? (prime_q - 1'b1) : prime_q;
  end

  // State registers
  always_ff @(posedge clk) begin
    if (reset) begin
      pending_q   <= '0;
      enable_q    <= '0;
      mode_q      <= '0;
      polarity_q  <= '0;
      for (int i = 0; i < NUM_SRC; i++) begin
        level_q[i] <= 3'd0;
      end
      prime_q     <= PRIME_INIT;
      state_q     <= ACK_IDLE;
      ipl_n_q     <= IPL_NONE;
      ack_valid_q <= 1'b0;
      ack_hit_q   <= 1'b0;
      ack_src_q   <= 4'd0;
    end else begin
      pending_q   <= pending_d;
      enable_q    <= enable_d;
      mode_q      <= mode_d;
      polarity_q  <= polarity_d;
      for (int i = 0; i < NUM_SRC; i++) begin
        level_q[i] <= level_d[i];
      end
      prime_q     <= prime_d;
      state_q     <= state_d;
      ipl_n_q     <= ipl_n_d;
      ack_valid_q <= ack_valid_d;
      ack_hit_q   <= ack_hit_d;
      ack_src_q   <= ack_src_d;
    end
  end

  // Readback vectors: unimplemented sources and unused LEVEL bits read 0
  always_comb begin
    pend16 = '0;
    en16   = '0;
    mode16 = '0;
    pol16  = '0;
    for (int w = 0; w < 4; w++) begin
      lvl16[w] = '0;
    end
    for (int i = 0; i < NUM_SRC; i++) begin
      pend16[i] = pending_q[i];
      en16[i]   = enable_q[i];
      mode16[i] = mode_q[i];
      pol16[i]  = polarity_q[i];
      lvl16[i / 4][(i % 4) * 4 +: 3] = level_q[i];
    end
  end

  // Combinational read mux
  always_comb begin
    dout = '0;
    unique case (address)
      IRQ_PENDING:  dout = pend16;
      IRQ_ENABLE:   dout = en16;
      IRQ_MODE:     dout = mode16;
      IRQ_POLARITY: dout = pol16;
      default:      dout = lvl16[address[1:0]];
    endcase
  end

  assign ipl_n     = ipl_n_q;
  assign ack_valid = ack_valid_q;
  assign ack_hit   = ack_hit_q;
  assign ack_src   = ack_src_q;

endmodule
